// File: rtl/cpu_types_pkg.sv
// Shared pipeline-control types: hazard FSM states and the per-latch control bundle.
package cpu_types_pkg;

  localparam int unsigned RegAddrW = 5;

  typedef enum logic [1:0] {StRun, StDwait, StLuse, StHalted} hz_state_t;

  typedef struct packed {
    logic pc_en;
    logic fetch_freeze;
    logic fetch_flush;
    logic decode_freeze;
    logic decode_flush;
    logic execute_freeze;
    logic memory_freeze;
  } hz_ctrl_t;

  localparam hz_ctrl_t CtrlAdvance  = '{pc_en: 1'b1, default: 1'b0};
  localparam hz_ctrl_t CtrlReset    = '{fetch_flush: 1'b1, decode_flush: 1'b1, default: 1'b0};
  localparam hz_ctrl_t CtrlFreeze   = '{fetch_freeze: 1'b1, decode_freeze: 1'b1,
                                        execute_freeze: 1'b1, memory_freeze: 1'b1,
                                        default: 1'b0};
  localparam hz_ctrl_t CtrlRedirect = '{pc_en: 1'b1, fetch_flush: 1'b1, decode_flush: 1'b1,
                                        default: 1'b0};
  localparam hz_ctrl_t CtrlBubble   = '{fetch_freeze: 1'b1, decode_flush: 1'b1, default: 1'b0};
  localparam hz_ctrl_t CtrlMiss     = '{fetch_flush: 1'b1, default: 1'b0};

  // A latch that is held must not also be cleared.
  function automatic hz_ctrl_t freeze_wins(hz_ctrl_t c);
    hz_ctrl_t r;
    r              = c;
    r.fetch_flush  = c.fetch_flush & ~c.fetch_freeze;
    r.decode_flush = c.decode_flush & ~c.decode_freeze;
    return r;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: a load in execute writes a register the decode instruction reads.
module hazard_detect
  import cpu_types_pkg::*;
(
  input  logic [RegAddrW-1:0] dec_rs_i,
  input  logic [RegAddrW-1:0] dec_rt_i,
  input  logic                dec_uses_rt_i,
  input  logic                ex_memread_i,
  input  logic [RegAddrW-1:0] ex_rd_i,
  output logic                lu_hazard_o
);

  logic rs_match, rt_match;

  always_comb begin
    rs_match    = (ex_rd_i == dec_rs_i);
    rt_match    = dec_uses_rt_i & (ex_rd_i == dec_rt_i);
    // r0 is hardwired, so a load targeting it never creates a dependency.
    lu_hazard_o = ex_memread_i & (ex_rd_i != '0) & (rs_match | rt_match);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline latch sequencer: resolves halt, data wait, redirect, load-use and fetch miss
// in fixed priority and keeps saturating stall/flush counters.
module pipeline_hazard_ctrl
  import cpu_types_pkg::*;
#(
  parameter int unsigned LU_BUBBLES = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                ihit,
  input  logic                dhit,
  input  logic                mem_dreq,
  input  logic [RegAddrW-1:0] dec_rs,
  input  logic [RegAddrW-1:0] dec_rt,
  input  logic                dec_uses_rt,
  input  logic                ex_memread,
  input  logic [RegAddrW-1:0] ex_rd,
  input  logic                ex_redirect,
  input  logic                mem_halt,
  output logic                pc_en,
  output logic                fetch_freeze,
  output logic                fetch_flush,
  output logic                decode_freeze,
  output logic                decode_flush,
  output logic                execute_freeze,
  output logic                memory_freeze,
  output logic                halt,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    flush_cnt
);

  localparam logic [1:0] LuInit = 2'(LU_BUBBLES - 1);

  hz_state_t        state_q, state_d;
  logic [1:0]       lu_cnt_q, lu_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  hz_ctrl_t         ctrl, ctrl_out;
  logic             dwait, redirect_taken, lu_hazard, stall_inc;

  hazard_detect u_hazard_detect (
    .dec_rs_i      (dec_rs),
    .dec_rt_i      (dec_rt),
    .dec_uses_rt_i (dec_uses_rt),
    .ex_memread_i  (ex_memread),
    .ex_rd_i       (ex_rd),
    .lu_hazard_o   (lu_hazard)
  );

  always_comb begin
    ctrl           = CtrlAdvance;
    state_d        = state_q;
    lu_cnt_d       = lu_cnt_q;
    redirect_taken = 1'b0;
    dwait          = mem_dreq & ~dhit;

    if (state_q == StHalted) begin
      ctrl = CtrlFreeze;
    end else if (dwait) begin
      ctrl    = CtrlFreeze;
      state_d = StDwait;
    end else if (ex_redirect) begin
      // A redirect held by the frozen EX latch lands here on the first non-wait cycle.
      ctrl           = CtrlRedirect;
      redirect_taken = 1'b1;
      state_d        = StRun;
      lu_cnt_d       = '0;
    end else if (state_q == StLuse) begin
      ctrl     = CtrlBubble;
      lu_cnt_d = lu_cnt_q - 2'd1;
      state_d  = (lu_cnt_q == 2'd1) ? StRun : StLuse;
    end else if (lu_hazard) begin
      ctrl     = CtrlBubble;
      lu_cnt_d = LuInit;
      state_d  = (LU_BUBBLES > 1) ? StLuse : StRun;
    end else if (!ihit) begin
      ctrl     = CtrlMiss;
      state_d  = StRun;
      lu_cnt_d = '0;
    end else begin
      state_d  = StRun;
      lu_cnt_d = '0;
    end

    if (state_q != StHalted && !dwait && mem_halt) begin
      state_d = StHalted;
    end

    ctrl = freeze_wins(ctrl);
  end

  always_comb begin
    stall_inc   = (state_q != StHalted) & ~ctrl.pc_en;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_inc && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (redirect_taken && flush_cnt_q != '1) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q     <= StRun;
      lu_cnt_q    <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      lu_cnt_q    <= lu_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    ctrl_out = nRST ? ctrl : CtrlReset;
    pc_en          = ctrl_out.pc_en;
    fetch_freeze   = ctrl_out.fetch_freeze;
    fetch_flush    = ctrl_out.fetch_flush;
    decode_freeze  = ctrl_out.decode_freeze;
    decode_flush   = ctrl_out.decode_flush;
    execute_freeze = ctrl_out.execute_freeze;
    memory_freeze  = ctrl_out.memory_freeze;
    halt           = nRST & (state_q == StHalted);
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scenario bench for pipeline_hazard_ctrl: expected latch controls are queued as each cycle
// is driven and popped when outputs are sampled on the falling edge.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned CntW = 4;

  // {pc_en, fetch_freeze, fetch_flush, decode_freeze, decode_flush, ex_freeze, mem_freeze, halt}
  localparam logic [7:0] ORst   = 8'b0010_1000;
  localparam logic [7:0] OAdv   = 8'b1000_0000;
  localparam logic [7:0] OLu    = 8'b0100_1000;
  localparam logic [7:0] ODw    = 8'b0101_0110;
  localparam logic [7:0] ORedir = 8'b1010_1000;
  localparam logic [7:0] OMiss  = 8'b0010_0000;
  localparam logic [7:0] OHalt  = 8'b0101_0111;

  typedef struct packed {
    logic       nrst;
    logic       ihit;
    logic       dhit;
    logic       mem_dreq;
    logic [4:0] dec_rs;
    logic [4:0] dec_rt;
    logic       dec_uses_rt;
    logic       ex_memread;
    logic [4:0] ex_rd;
    logic       ex_redirect;
    logic       mem_halt;
  } in_t;

  logic            CLK = 1'b0;
  logic            nRST = 1'b0;
  logic            ihit = 1'b1, dhit = 1'b0, mem_dreq = 1'b0;
  logic [4:0]      dec_rs = '0, dec_rt = '0, ex_rd = '0;
  logic            dec_uses_rt = 1'b0, ex_memread = 1'b0, ex_redirect = 1'b0, mem_halt = 1'b0;
  logic            pc_en, fetch_freeze, fetch_flush, decode_freeze, decode_flush;
  logic            execute_freeze, memory_freeze, halt;
  logic [CntW-1:0] stall_cnt, flush_cnt;
  logic [7:0]      out_vec;
  logic [7:0]      sb_q[$];
  int              n_vec = 0;
  int              n_fail = 0;

  pipeline_hazard_ctrl #(
    .LU_BUBBLES (1),
    .CNT_W      (CntW)
  ) dut (
    .CLK            (CLK),
    .nRST           (nRST),
    .ihit           (ihit),
    .dhit           (dhit),
    .mem_dreq       (mem_dreq),
    .dec_rs         (dec_rs),
    .dec_rt         (dec_rt),
    .dec_uses_rt    (dec_uses_rt),
    .ex_memread     (ex_memread),
    .ex_rd          (ex_rd),
    .ex_redirect    (ex_redirect),
    .mem_halt       (mem_halt),
    .pc_en          (pc_en),
    .fetch_freeze   (fetch_freeze),
    .fetch_flush    (fetch_flush),
    .decode_freeze  (decode_freeze),
    .decode_flush   (decode_flush),
    .execute_freeze (execute_freeze),
    .memory_freeze  (memory_freeze),
    .halt           (halt),
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
  );

  always #5 CLK = ~CLK;

  assign out_vec = {pc_en, fetch_freeze, fetch_flush, decode_freeze, decode_flush,
                    execute_freeze, memory_freeze, halt};

  function automatic in_t idle();
    in_t v;
    v      = '0;
    v.nrst = 1'b1;
    v.ihit = 1'b1;
    return v;
  endfunction

  // Apply one cycle of stimulus just after the rising edge and queue its expected controls.
  task automatic drive(input in_t v, input logic [7:0] exp);
    @(posedge CLK);
    #1;
    nRST        = v.nrst;
    ihit        = v.ihit;
    dhit        = v.dhit;
    mem_dreq    = v.mem_dreq;
    dec_rs      = v.dec_rs;
    dec_rt      = v.dec_rt;
    dec_uses_rt = v.dec_uses_rt;
    ex_memread  = v.ex_memread;
    ex_rd       = v.ex_rd;
    ex_redirect = v.ex_redirect;
    mem_halt    = v.mem_halt;
    sb_q.push_back(exp);
  endtask

  task automatic do_reset();
    in_t        v;
    logic [7:0] exp;
    v      = idle();
    v.nrst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(v, ORst);
      @(negedge CLK);
      exp = sb_q.pop_front();
      n_vec++;
      if (out_vec !== exp) begin
        $display("FAIL reset_out[%0d] got=%b want=%b", i, out_vec, exp);
        n_fail++;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if (stall_cnt !== '0 || flush_cnt !== '0) begin
      $display("FAIL reset_cnt got stall=%0d flush=%0d want 0 0", stall_cnt, flush_cnt);
      n_fail++;
    end
  endtask

  task automatic test_load_use();
    in_t        v[5];
    logic [7:0] e[5];
    logic [7:0] exp;
    do_reset();
    v[0] = idle(); v[0].ex_memread = 1; v[0].ex_rd = 8; v[0].dec_rs = 8; e[0] = OLu;
    v[1] = idle(); e[1] = OAdv;
    v[2] = idle(); v[2].ex_memread = 1; v[2].ex_rd = 5; v[2].dec_rt = 5;
    v[2].dec_uses_rt = 1; e[2] = OLu;
    v[3] = idle(); v[3].ex_memread = 1; v[3].ex_rd = 5; v[3].dec_rt = 5; e[3] = OAdv;
    v[4] = idle(); v[4].ex_memread = 1; e[4] = OAdv;  // ex_rd == dec_rs == r0
    for (int i = 0; i < 5; i++) begin
      drive(v[i], e[i]);
      @(negedge CLK);
      exp = sb_q.pop_front();
      n_vec++;
      if (out_vec !== exp) begin
        $display("FAIL load_use[%0d] got=%b want=%b", i, out_vec, exp);
        n_fail++;
      end
      if (i == 1) begin
        n_vec++;
        if (stall_cnt !== 4'd1) begin
          $display("FAIL load_use_stall1 got=%0d want=1", stall_cnt);
          n_fail++;
        end
      end
    end
    n_vec++;
    if (stall_cnt !== 4'd2) begin
      $display("FAIL load_use_stall2 got=%0d want=2", stall_cnt);
      n_fail++;
    end
  endtask

  task automatic test_dwait();
    in_t        v;
    logic [7:0] exp;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      v          = idle();
      v.mem_dreq = 1'b1;
      v.dhit     = (i == 4);
      drive(v, (i == 4) ? OAdv : ODw);
      @(negedge CLK);
      exp = sb_q.pop_front();
      n_vec++;
      if (out_vec !== exp) begin
        $display("FAIL dwait[%0d] got=%b want=%b", i, out_vec, exp);
        n_fail++;
      end
    end
    n_vec++;
    if (stall_cnt !== 4'd4) begin
      $display("FAIL dwait_stall got=%0d want=4", stall_cnt);
      n_fail++;
    end
  endtask

  task automatic test_redirect();
    in_t        v[5];
    logic [7:0] e[5];
    logic [7:0] exp;
    do_reset();
    // Redirect and load-use together: redirect wins, no bubble follows.
    v[0] = idle(); v[0].ex_redirect = 1; v[0].ex_memread = 1; v[0].ex_rd = 8;
    v[0].dec_rs = 8; e[0] = ORedir;
    v[1] = idle(); e[1] = OAdv;
    // Redirect held across a data wait, applied once the wait clears.
    v[2] = idle(); v[2].mem_dreq = 1; v[2].ex_redirect = 1; e[2] = ODw;
    v[3] = idle(); v[3].mem_dreq = 1; v[3].dhit = 1; v[3].ex_redirect = 1; e[3] = ORedir;
    v[4] = idle(); v[4].ihit = 0; e[4] = OMiss;
    for (int i = 0; i < 5; i++) begin
      drive(v[i], e[i]);
      @(negedge CLK);
      exp = sb_q.pop_front();
      n_vec++;
      if (out_vec !== exp) begin
        $display("FAIL redirect[%0d] got=%b want=%b", i, out_vec, exp);
        n_fail++;
      end
      if (i == 1) begin
        n_vec++;
        if (flush_cnt !== 4'd1 || stall_cnt !== 4'd0) begin
          $display("FAIL redirect_cnt got flush=%0d stall=%0d want 1 0", flush_cnt, stall_cnt);
          n_fail++;
        end
      end
    end
    n_vec++;
    if (flush_cnt !== 4'd2 || stall_cnt !== 4'd1) begin
      $display("FAIL redirect_cnt2 got flush=%0d stall=%0d want 2 1", flush_cnt, stall_cnt);
      n_fail++;
    end
  endtask

  task automatic test_halt();
    in_t        v[7];
    logic [7:0] e[7];
    logic [7:0] exp;
    do_reset();
    v[0] = idle(); v[0].mem_dreq = 1; v[0].mem_halt = 1; e[0] = ODw;
    v[1] = idle(); v[1].mem_dreq = 1; v[1].mem_halt = 1; e[1] = ODw;
    v[2] = idle(); v[2].mem_dreq = 1; v[2].dhit = 1; v[2].mem_halt = 1; e[2] = OAdv;
    v[3] = idle(); e[3] = OHalt;
    v[4] = idle(); v[4].ex_redirect = 1; v[4].ihit = 0; e[4] = OHalt;
    v[5] = idle(); v[5].mem_dreq = 1; e[5] = OHalt;
    v[6] = idle(); v[6].ex_memread = 1; v[6].ex_rd = 3; v[6].dec_rs = 3; e[6] = OHalt;
    for (int i = 0; i < 7; i++) begin
      drive(v[i], e[i]);
      @(negedge CLK);
      exp = sb_q.pop_front();
      n_vec++;
      if (out_vec !== exp) begin
        $display("FAIL halt[%0d] got=%b want=%b", i, out_vec, exp);
        n_fail++;
      end
    end
    n_vec++;
    if (stall_cnt !== 4'd2 || flush_cnt !== 4'd0) begin
      $display("FAIL halt_cnt got stall=%0d flush=%0d want 2 0", stall_cnt, flush_cnt);
      n_fail++;
    end
    do_reset();
    drive(idle(), OAdv);
    @(negedge CLK);
    exp = sb_q.pop_front();
    n_vec++;
    if (out_vec !== exp) begin
      $display("FAIL halt_cleared got=%b want=%b", out_vec, exp);
      n_fail++;
    end
  endtask

  task automatic test_reset_mid_dwait();
    in_t        v[3];
    logic [7:0] e[3];
    logic [7:0] exp;
    do_reset();
    v[0] = idle(); v[0].mem_dreq = 1; e[0] = ODw;
    v[1] = idle(); v[1].mem_dreq = 1; v[1].nrst = 0; e[1] = ORst;
    v[2] = idle(); e[2] = OAdv;
    for (int i = 0; i < 3; i++) begin
      drive(v[i], e[i]);
      @(negedge CLK);
      exp = sb_q.pop_front();
      n_vec++;
      if (out_vec !== exp) begin
        $display("FAIL reset_mid_dwait[%0d] got=%b want=%b", i, out_vec, exp);
        n_fail++;
      end
    end
    n_vec++;
    if (stall_cnt !== 4'd0) begin
      $display("FAIL reset_mid_dwait_cnt got=%0d want=0", stall_cnt);
      n_fail++;
    end
  endtask

  task automatic test_saturation();
    in_t        v;
    logic [7:0] exp;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      v      = idle();
      v.ihit = 1'b0;
      drive(v, OMiss);
      @(negedge CLK);
      exp = sb_q.pop_front();
      n_vec++;
      if (out_vec !== exp) begin
        $display("FAIL sat_miss[%0d] got=%b want=%b", i, out_vec, exp);
        n_fail++;
      end
    end
    n_vec++;
    if (stall_cnt !== 4'hf) begin
      $display("FAIL sat_stall got=%0d want=15", stall_cnt);
      n_fail++;
    end
    for (int i = 0; i < 18; i++) begin
      v             = idle();
      v.ex_redirect = 1'b1;
      drive(v, ORedir);
      @(negedge CLK);
      exp = sb_q.pop_front();
      n_vec++;
      if (out_vec !== exp) begin
        $display("FAIL sat_redir[%0d] got=%b want=%b", i, out_vec, exp);
        n_fail++;
      end
    end
    n_vec++;
    if (flush_cnt !== 4'hf || stall_cnt !== 4'hf) begin
      $display("FAIL sat_flush got flush=%0d stall=%0d want 15 15", flush_cnt, stall_cnt);
      n_fail++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_use();
    test_dwait();
    test_redirect();
    test_halt();
    test_reset_mid_dwait();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
